// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
//   Core side : req, is_store, funct3, addr, store_data -> busy, done, fault, load_data
//   Memory    : a_dm, we, wd -> rd (combinational read of word a_dm)
// slave modport is the unit itself; master is the core/memory environment.
interface load_store_unit_if #(
  parameter int unsigned MemAw = 5
) ();
  logic              req;
  logic              is_store;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       store_data;
  logic              busy;
  logic              done;
  logic              fault;
  logic [31:0]       load_data;
  logic [MemAw-1:0]  a_dm;
  logic              we;
  logic [31:0]       wd;
  logic [31:0]       rd;

  modport slave (
    input  req, is_store, funct3, addr, store_data, rd,
    output busy, done, fault, load_data, a_dm, we, wd
  );

  modport master (
    output req, is_store, funct3, addr, store_data, rd,
    input  busy, done, fault, load_data, a_dm, we, wd
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32 load/store initiator for a word-wide memory with combinational
// reads and whole-word writes. Sub-word stores are done as read-modify-write.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : load_store_unit_if.slave (core request/response + memory bus)
module load_store_unit #(
  parameter int unsigned MemAw = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  load_store_unit_if.slave    bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StRmwRd,
    StRmwWr,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [MemAw+1:0]  addr_q, addr_d;
  logic [31:0]       store_data_q, store_data_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [31:0]       merged_q, merged_d;
  logic              fault_q, fault_d;

  logic              req_legal;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  // Width code and alignment check on the raw request.
  always_comb begin
    req_legal = 1'b0;
    case (bus.funct3)
      3'b000:  req_legal = 1'b1;
      3'b001:  req_legal = ~bus.addr[0];
      3'b010:  req_legal = (bus.addr[1:0] == 2'b00);
      3'b100:  req_legal = ~bus.is_store;
      3'b101:  req_legal = ~bus.is_store & ~bus.addr[0];
      default: req_legal = 1'b0;
    endcase
  end

  // Little-endian lane select from the word currently addressed.
  always_comb begin
    rd_byte = bus.rd[7:0];
    case (addr_q[1:0])
      2'd0:    rd_byte = bus.rd[7:0];
      2'd1:    rd_byte = bus.rd[15:8];
      2'd2:    rd_byte = bus.rd[23:16];
      default: rd_byte = bus.rd[31:24];
    endcase
    rd_half = addr_q[1] ? bus.rd[31:16] : bus.rd[15:0];
  end

  always_comb begin
    load_ext = bus.rd;
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'h0, rd_byte};
      3'b101:  load_ext = {16'h0, rd_half};
      default: load_ext = bus.rd;
    endcase
  end

  // funct3_q[0] distinguishes SH from SB; SW never reaches the merge path.
  always_comb begin
    merged = bus.rd;
    if (funct3_q[0]) begin
      if (addr_q[1]) merged[31:16] = store_data_q[15:0];
      else           merged[15:0]  = store_data_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = store_data_q[7:0];
        2'd1:    merged[15:8]  = store_data_q[7:0];
        2'd2:    merged[23:16] = store_data_q[7:0];
        default: merged[31:24] = store_data_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    load_data_d  = load_data_q;
    merged_d     = merged_q;
    fault_d      = fault_q;

    case (state_q)
      StIdle: begin
        if (bus.req) begin
          funct3_d     = bus.funct3;
          addr_d       = bus.addr[MemAw+1:0];
          store_data_d = bus.store_data;
          fault_d      = ~req_legal;
          if (!req_legal) begin
            state_d = StDone;
            if (!bus.is_store) load_data_d = '0;
          end else if (!bus.is_store) begin
            state_d = StLoad;
          end else if (bus.funct3 == 3'b010) begin
            state_d = StWrite;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad: begin
        load_data_d = load_ext;
        state_d     = StDone;
      end
      StWrite: state_d = StDone;
      StRmwRd: begin
        merged_d = merged;
        state_d  = StRmwWr;
      end
      StRmwWr: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      funct3_q     <= '0;
      addr_q       <= '0;
      store_data_q <= '0;
      load_data_q  <= '0;
      merged_q     <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      load_data_q  <= load_data_d;
      merged_q     <= merged_d;
      fault_q      <= fault_d;
    end
  end

  // All outputs decode registered state only, so WE cannot glitch on inputs.
  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.done      = (state_q == StDone);
    bus.fault     = (state_q == StDone) & fault_q;
    bus.load_data = load_data_q;
    bus.a_dm      = addr_q[MemAw+1:2];
    bus.we        = 1'b0;
    bus.wd        = '0;
    case (state_q)
      StWrite: begin
        bus.we = 1'b1;
        bus.wd = store_data_q;
      end
      StRmwWr: begin
        bus.we = 1'b1;
        bus.wd = merged_q;
      end
      default: ;
    endcase
  end

endmodule
